// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  stall_req_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   ONE      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE2     = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   MIN      = {1'b1, {(W-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      f3_q;
  logic            neg_q;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  opa;
  logic [W-1:0]    opb;

  logic            s1, s2;
  logic [W-1:0]    abs1, abs2;
  logic            div_zero, div_ovf, special;
  logic [W-1:0]    special_res;
  logic            start_ok;

  logic [W:0]      trial;
  logic [2*W-1:0]  div_next, mul_next, prod;
  logic [W-1:0]    quo, rem, fix_res;

  // Operand decode: magnitudes, result signs and the early-exit divide cases
  always_comb begin
    s1 = 1'b0;
    s2 = 1'b0;
    case (funct3_i)
      F_MULH, F_DIV, F_REM: begin
        s1 = op1_i[W-1];
        s2 = op2_i[W-1];
      end
      F_MULHSU: s1 = op1_i[W-1];
      default: ;
    endcase
    abs1 = s1 ? ~op1_i + ONE : op1_i;
    abs2 = s2 ? ~op2_i + ONE : op2_i;
    div_zero = funct3_i[2] && (op2_i == '0);
    div_ovf  = ((funct3_i == F_DIV) || (funct3_i == F_REM)) && (op1_i == MIN) && (&op2_i);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = funct3_i[1] ? op1_i : '1;
    else          special_res = funct3_i[1] ? '0 : MIN;
    start_ok = start_i & ~flush_i;
  end

  // Divide keeps remainder in acc's high half and the quotient grows in the low half;
  // trial is one bit wider so the shifted-out remainder MSB is never lost.
  always_comb begin
    trial = acc[2*W-1:W-1] - {1'b0, opb};
    if (trial[W]) div_next = {acc[2*W-2:0], 1'b0};
    else          div_next = {trial[W-1:0], acc[W-2:0], 1'b1};
    mul_next = acc + (opb[0] ? opa : '0);
    prod = neg_q ? ~acc + ONE2 : acc;
    quo  = neg_q ? ~acc[W-1:0] + ONE : acc[W-1:0];
    rem  = neg_q ? ~acc[2*W-1:W] + ONE : acc[2*W-1:W];
    case (f3_q)
      F_MUL:         fix_res = prod[W-1:0];
      F_DIV, F_DIVU: fix_res = quo;
      F_REM, F_REMU: fix_res = rem;
      default:       fix_res = prod[2*W-1:W];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    done_o      = (state == DONE);
    busy_o      = (state != IDLE);
    stall_req_o = (state == CALC) || (state == FIX) || ((state == IDLE) && start_ok);
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state_nxt = special ? DONE : CALC;
        CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    if (!hold_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      f3_q     <= '0;
      neg_q    <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          f3_q  <= funct3_i;
          neg_q <= (funct3_i == F_REM) ? s1 : (s1 ^ s2);
          cnt   <= '0;
          opb   <= abs2;
          if (funct3_i[2]) begin
            acc <= {{W{1'b0}}, abs1};
            opa <= '0;
          end else begin
            acc <= '0;
            opa <= {{W{1'b0}}, abs1};
          end
          if (special) result_o <= special_res;
        end
        CALC: begin
          cnt <= cnt + CNT_ONE;
          if (f3_q[2]) begin
            acc <= div_next;
          end else begin
            acc <= mul_next;
            opa <= {opa[2*W-2:0], 1'b0};
            opb <= {1'b0, opb[W-1:1]};
          end
        end
        FIX: if (!flush_i) result_o <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
